// File: rtl/div_arbiter.sv
// Two-port round-robin arbiter and sequencer for the shared signed divider.
// Optional macro DIV_ZERO_BYPASS_EN: a zero divisor skips the settle window.
module div_arbiter #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] dividend0,
  input  logic [WIDTH-1:0] divisor0,
  input  logic             req1,
  input  logic [WIDTH-1:0] dividend1,
  input  logic [WIDTH-1:0] divisor1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             exception,
  output logic             busy,
  output logic [WIDTH-1:0] div_dd,
  output logic [WIDTH-1:0] div_ds,
  input  logic [WIDTH-1:0] div_q,
  input  logic             div_ex
);

  typedef enum logic [1:0] {IDLE, RUN, DONE, ZERO} state_t;

  state_t           state, next_state;
  logic [3:0]       count;
  logic             owner;
  logic             last;
  logic             first;
  logic [WIDTH-1:0] op_dd, op_ds;

  logic             any_req;
  logic             winner;
  logic [WIDTH-1:0] win_dd, win_ds;

  // On a tie the requester that was not served last wins.
  assign any_req = req0 | req1;
  assign winner  = (req0 && req1) ? ~last : req1;
  assign win_dd  = winner ? dividend1 : dividend0;
  assign win_ds  = winner ? divisor1  : divisor0;

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (any_req) begin
`ifdef DIV_ZERO_BYPASS_EN
          if (win_ds == '0)
            next_state = ZERO;
          else
            next_state = RUN;
`else
          next_state = RUN;
`endif
        end
      end
      RUN:     if (count == 4'd0) next_state = DONE;
      DONE:    next_state = IDLE;
      ZERO:    next_state = DONE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      count     <= 4'd0;
      owner     <= 1'b0;
      last      <= 1'b1;
      first     <= 1'b0;
      op_dd     <= '0;
      op_ds     <= '0;
      result    <= '0;
      exception <= 1'b0;
    end else begin
      state <= next_state;
      first <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner <= winner;
            last  <= winner;
            first <= 1'b1;
            count <= 4'(LATENCY - 1);
            // The bypass path leaves the divider inputs untouched.
            if (next_state == RUN) begin
              op_dd <= win_dd;
              op_ds <= win_ds;
            end
          end
        end
        RUN: begin
          if (count == 4'd0) begin
            result    <= div_q;
            exception <= div_ex;
          end else begin
            count <= count - 4'd1;
          end
        end
        ZERO: begin
          result    <= '0;
          exception <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign gnt0   = first & ~owner;
  assign gnt1   = first &  owner;
  assign done0  = (state == DONE) & ~owner;
  assign done1  = (state == DONE) &  owner;
  assign busy   = (state != IDLE);
  assign div_dd = op_dd;
  assign div_ds = op_ds;

endmodule

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
- Sequencing controller and two-port arbiter for the shared signed 32-bit integer divider in the calculations datapath.
- Requester 0 is the CPU multdiv path; requester 1 is the guidance/trajectory unit.
- Latches one request at a time, holds operands stable on the divider for a fixed settle window, then captures the quotient and divide-by-zero flag and returns them to the winning requester.
- Round-robin fairness.

Parameters:
- WIDTH, 32: operand and quotient width.
- LATENCY, 4: cycles the operands are held on the divider before capture; legal range 1..15.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  requester 0 request.
- dividend0  in  WIDTH  requester 0 dividend, signed.
- divisor0  in  WIDTH  requester 0 divisor, signed.
- req1  in  1  requester 1 request.
- dividend1  in  WIDTH  requester 1 dividend.
- divisor1  in  WIDTH  requester 1 divisor.
- gnt0  out  1  one-cycle pulse: requester 0 operands accepted.
- gnt1  out  1  one-cycle pulse: requester 1 operands accepted.
- done0  out  1  one-cycle pulse: result for requester 0 valid.
- done1  out  1  one-cycle pulse: result for requester 1 valid.
- result  out  WIDTH  captured quotient.
- exception  out  1  captured divide-by-zero flag.
- busy  out  1  high in any state other than IDLE.
- div_dd  out  WIDTH  dividend to divider.
- div_ds  out  WIDTH  divisor to divider.
- div_q  in  WIDTH  quotient from divider; combinational, truncating, 0 on exception.
- div_ex  in  1  divider divide-by-zero flag.

Behaviour:
- Clock and reset: one clock (clock); reset is synchronous and active-high (reset).
- Reset values: all outputs are 0, including div_dd, div_ds, result and exception. State is IDLE, cycle counter is 0, and the round-robin pointer last=1, so requester 0 wins the first tie.
- IDLE state:
  - req0/req1 are sampled only in IDLE.
  - One requester high: it wins.
  - Both high: the one not equal to last wins.
  - On the edge, the winner's operands are latched into the operand registers, owner and last are set to the winner, the counter is loaded to LATENCY-1, and the state moves to RUN.
- RUN state:
  - gntN is high in the first RUN cycle only.
  - div_dd/div_ds always drive the operand registers.
  - The counter decrements each cycle. At the counter=0 edge, div_q goes to result and div_ex goes to exception, and the state moves to DONE.
  - RUN lasts exactly LATENCY cycles.
- DONE state:
  - doneN (N=owner) is high for exactly one cycle, and result/exception are valid.
  - Next state is IDLE. result/exception hold their values until the next capture.
- Latency: req sampled at edge t; gnt in cycle t+1; done in cycle t+LATENCY+1. The earliest next grant is cycle t+LATENCY+3, so the request-to-request throughput is LATENCY+2 cycles.
- Requester rules:
  - Hold reqN and operands stable until gntN is seen.
  - Operands may change the cycle after gntN.
  - reqN still high in the next IDLE counts as a new request.
  - Requests arriving in RUN/DONE wait; they are not lost as long as they are held.
- Arithmetic: the controller performs no arithmetic on operands. Sign, truncation and zero handling belong to the divider; exception=1 implies result=0 per divider contract.
- Signal invariants:
  - gnt0 and gnt1 are never high together; likewise done0 and done1.
  - busy=0 only in IDLE.
- Reset mid-operation: an in-flight request is discarded and no done pulse is issued. All state and outputs return to reset values on the next cycle.

Optional Feature:
- Macro: DIV_ZERO_BYPASS_EN.
- Defined:
  - In IDLE, if the winner's divisor == 0, skip RUN.
  - Latch result=0 and exception=1 directly and go to DONE next.
  - gntN and doneN pulse in consecutive cycles: gnt in t+1, done in t+2.
  - div_dd/div_ds keep their previous values.
- Not defined: a zero divisor takes the normal LATENCY path, and exception comes from div_ex.

Test Plan (LATENCY=4, bench divider model = truncating signed divide):
- Single request: req0, 100 / -7 at edge t -> gnt0 in t+1, div_dd=100 and div_ds=-7 for cycles t+1..t+4, done0 in t+5, result=-14, exception=0, busy low in t+6.
- Tie: req0 and req1 asserted together and held; requester 0 is 50/5, requester 1 is -9/2 -> requester 0 served first (result 10); requester 1 is granted in the next IDLE (result -4, done1); the next tie goes to requester 0 again.
- Divide by zero, macro off: req1, 7/0 -> done1 at t+5, result=0, exception=1.
- Divide by zero, macro on: req1, 7/0 -> done1 at t+2, result=0, exception=1.
- Back-to-back: req0 held high with new operands after each gnt0, 3 requests -> gnt0 pulses spaced 6 cycles apart, each done0 carrying the correct quotient.
- Reset mid-run: assert reset in the 2nd RUN cycle -> no done0/done1 pulse at all; next cycle all outputs are 0 and busy=0; a fresh req1 then completes normally.
